// File: rtl/demux_xy_to_chan_pkg.sv
// Shared lightclick payload types and route-select encoding.
package lightclick_types_pkg;
  typedef struct packed { logic x; } X;
  typedef union packed { logic x; X y; } Y;
  typedef union packed { logic x; X y; } IJ;

  typedef logic [1:0] sel_t;
  localparam sel_t SEL_NONE = 2'b00;
  localparam sel_t SEL_CH1  = 2'b01;
  localparam sel_t SEL_CH2  = 2'b10;
  localparam sel_t SEL_BOTH = 2'b11;

  // Bit 0 of the select steers to chan1, bit 1 to chan2.
  function automatic logic sel_ch1(sel_t s);
    return s[0];
  endfunction

  function automatic logic sel_ch2(sel_t s);
    return s[1];
  endfunction
endpackage

// File: rtl/demux_xy_to_chan_if.sv
// Producer/consumer bundle of the xy -> chan1/chan2 demux.
interface demux_xy_to_chan_if
  import lightclick_types_pkg::*;
#(
  parameter int CNT_W = 4
) ();
  sel_t             ctrl;
  logic             xy_valid;
  IJ                xy;
  logic             xy_ready;
  logic             chan1_valid;
  Y                 chan1;
  logic             chan1_ready;
  logic             chan2_valid;
  Y                 chan2;
  logic             chan2_ready;
  logic             err;
  logic [CNT_W-1:0] drop_count;

  // Environment side: producer plus both consumers.
  modport master (
    output ctrl, xy_valid, xy, chan1_ready, chan2_ready,
    input  xy_ready, chan1_valid, chan1, chan2_valid, chan2, err, drop_count
  );

  // Block side.
  modport slave (
    input  ctrl, xy_valid, xy, chan1_ready, chan2_ready,
    output xy_ready, chan1_valid, chan1, chan2_valid, chan2, err, drop_count
  );
endinterface

// File: rtl/demux_xy_to_chan_fifo.sv
// Small per-channel FIFO; head is presented combinationally from storage.
module demux_fifo
  import lightclick_types_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic c,
  input  logic rst,
  input  logic push,
  input  Y     din,
  output logic full,
  input  logic pop,
  output Y     dout,
  output logic valid
);
  localparam int AW = $clog2(DEPTH);

  Y              mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign valid   = (cnt_q != '0);
  assign do_push = push && !full;
  assign do_pop  = pop && valid;
  // Writes never land on rd_q while non-empty, so the head only moves on pop
  // or on a push into an empty queue.
  assign dout    = mem_q[rd_q];

  // Storage, pointers (wrap mod DEPTH) and occupancy; reset discards all.
  always_ff @(posedge c or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= din;
        wr_q        <= wr_q + 1'b1;
      end
      if (do_pop) rd_q <= rd_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end
endmodule

// File: rtl/demux_xy_to_chan.sv
// Steers xy beats to chan1, chan2 or both; drops and counts illegal selects.
module demux_xy_to_chan
  import lightclick_types_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 4
) (
  input logic              c,
  input logic              rst,
  demux_xy_to_chan_if.slave bus
);
  logic             full1, full2;
  logic             xy_ready_d;
  logic             fire, push1, push2, illegal;
  logic             err_q, err_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  Y                 din;

  // Accept depends only on the select and current occupancy; a broadcast
  // waits until both queues have room so it is never split.
  always_comb begin
    xy_ready_d = 1'b1;
    case (bus.ctrl)
      SEL_CH1:  xy_ready_d = !full1;
      SEL_CH2:  xy_ready_d = !full2;
      SEL_BOTH: xy_ready_d = !full1 && !full2;
      default:  xy_ready_d = 1'b1;
    endcase
  end

  assign bus.xy_ready = xy_ready_d;
  assign fire         = bus.xy_valid && xy_ready_d;
  assign push1        = fire && sel_ch1(bus.ctrl);
  assign push2        = fire && sel_ch2(bus.ctrl);
  assign illegal      = fire && (bus.ctrl == SEL_NONE);
  assign din          = Y'(bus.xy);

  // Next error pulse and saturating drop count.
  always_comb begin
    err_d  = illegal;
    drop_d = drop_q;
    if (illegal && (drop_q != '1)) drop_d = drop_q + 1'b1;
  end

  // Error/drop registers.
  always_ff @(posedge c or posedge rst) begin
    if (rst) begin
      err_q  <= 1'b0;
      drop_q <= '0;
    end else begin
      err_q  <= err_d;
      drop_q <= drop_d;
    end
  end

  assign bus.err        = err_q;
  assign bus.drop_count = drop_q;

  demux_fifo #(.DEPTH(DEPTH)) u_fifo1 (
    .c(c), .rst(rst), .push(push1), .din(din), .full(full1),
    .pop(bus.chan1_ready), .dout(bus.chan1), .valid(bus.chan1_valid)
  );

  demux_fifo #(.DEPTH(DEPTH)) u_fifo2 (
    .c(c), .rst(rst), .push(push2), .din(din), .full(full2),
    .pop(bus.chan2_ready), .dout(bus.chan2), .valid(bus.chan2_valid)
  );
endmodule
